// File: rtl/chest_pkg.sv
// Shared constants and state encoding for the chest framework algorithm scheduler.
package chest_pkg;

    localparam int unsigned CHEST_ALGO_W    = 6;
    localparam int unsigned CHEST_NUM_ALGOS = 50;
    localparam int unsigned CHEST_NUM_WINGS = 6;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WARMUP     = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_GRANTED    = 3'd3,
        ST_RELEASE    = 3'd4
    } chest_state_e;

endpackage

// File: rtl/chest_rr_arbiter.sv
// Combinational rotating-priority pick: first set req bit at or above ptr, with wrap.
module chest_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   index
);

    int unsigned pos;
    logic        found;

    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[IDX_W'(pos)]) begin
                found                = 1'b1;
                winner[IDX_W'(pos)]  = 1'b1;
                index                = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/chest_algo_scheduler.sv
// Round-robin scheduler sharing the chest algorithm engine among NUM_REQ requesters.
// Optional CHEST_WARM_RETAIN_EN keeps the wings warm across same-id grants.
module chest_algo_scheduler
    import chest_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned ALGO_W        = CHEST_ALGO_W,
    parameter int unsigned NUM_ALGOS     = CHEST_NUM_ALGOS,
    parameter int unsigned NUM_WINGS     = CHEST_NUM_WINGS,
    parameter int unsigned READY_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ALGO_W-1:0] req_algo,
    input  logic [NUM_REQ-1:0]        done,
    input  logic                      fw_ready,
    output logic [ALGO_W-1:0]         algo_select,
    output logic [NUM_WINGS-1:0]      wing_en,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        reject,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
    localparam logic [NUM_WINGS-1:0] WING_ALL = '1;
    localparam logic [NUM_WINGS-1:0] WING_ONE = NUM_WINGS'(1);

    chest_state_e         state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d, idx_q, idx_d;
    logic [NUM_REQ-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ALGO_W-1:0]    algo_d;
    logic [NUM_WINGS-1:0] wing_d;
    logic [NUM_REQ-1:0]   grant_d, reject_d;
    logic                 terr_d, busy_d;
    logic [NUM_REQ-1:0]   win_oh;
    logic [IDX_W-1:0]     win_idx;
    logic [ALGO_W-1:0]    win_algo;
`ifdef CHEST_WARM_RETAIN_EN
    logic [4:0]           idle_cnt_q, idle_cnt_d;
`endif

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    chest_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win_oh),
        .index  (win_idx)
    );

    assign win_algo = req_algo[win_idx*ALGO_W +: ALGO_W];

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        algo_d   = algo_select;
        wing_d   = wing_en;
        grant_d  = grant;
        reject_d = '0;
        terr_d   = 1'b0;
`ifdef CHEST_WARM_RETAIN_EN
        idle_cnt_d = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    idx_d = win_idx;
                    sel_d = win_oh;
                    if (32'(win_algo) >= NUM_ALGOS) begin
                        reject_d = win_oh;
                        ptr_d    = ptr_inc(win_idx);
`ifdef CHEST_WARM_RETAIN_EN
                    end else if (wing_en == WING_ALL && win_algo == algo_select) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_READY;
                    end else if (wing_en != '0) begin
                        // Different id: drop the wings for a cycle, then re-arbitrate cold.
                        wing_d = '0;
                        algo_d = '0;
`endif
                    end else begin
                        algo_d  = win_algo;
                        wing_d  = WING_ONE;
                        state_d = ST_WARMUP;
                    end
                end
`ifdef CHEST_WARM_RETAIN_EN
                else if (wing_en != '0) begin
                    if (idle_cnt_q == 5'd31) begin
                        wing_d = '0;
                        algo_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 5'd1;
                    end
                end
`endif
            end
            ST_WARMUP: begin
                if (wing_en == WING_ALL) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_READY;
                end else begin
                    wing_d = {wing_en[NUM_WINGS-2:0], 1'b1};
                end
            end
            ST_WAIT_READY: begin
                if (fw_ready) begin
                    grant_d = sel_q;
                    state_d = ST_GRANTED;
                end else if (cnt_q == CNT_W'(READY_TIMEOUT - 1)) begin
                    terr_d   = 1'b1;
                    reject_d = sel_q;
                    state_d  = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GRANTED: begin
                // done beats a simultaneous ready loss.
                if (done[idx_q] || !req[idx_q]) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end else if (!fw_ready) begin
                    grant_d = '0;
                    terr_d  = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
`ifndef CHEST_WARM_RETAIN_EN
                wing_d = '0;
                algo_d = '0;
`endif
                ptr_d   = ptr_inc(idx_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            algo_select <= '0;
            wing_en     <= '0;
            grant       <= '0;
            reject      <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
`ifdef CHEST_WARM_RETAIN_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            algo_select <= algo_d;
            wing_en     <= wing_d;
            grant       <= grant_d;
            reject      <= reject_d;
            timeout_err <= terr_d;
            busy        <= busy_d;
`ifdef CHEST_WARM_RETAIN_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_chest_algo_scheduler.sv
// Self-checking bench for chest_algo_scheduler: directed scenarios plus randomized requesters.
module tb_chest_algo_scheduler;

    localparam int NR = 4;
    localparam int AW = 6;

    logic          clk, rst_n;
    logic [NR-1:0] req, done;
    logic [NR*AW-1:0] req_algo;
    logic          fw_ready;
    logic [AW-1:0] algo_select;
    logic [5:0]    wing_en;
    logic [NR-1:0] grant, reject;
    logic          timeout_err, busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    chest_algo_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_algo(req_algo), .done(done),
        .fw_ready(fw_ready), .algo_select(algo_select), .wing_en(wing_en),
        .grant(grant), .reject(reject), .timeout_err(timeout_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner plus counts of lit wings / wait cycles.
    int         m_ptr, m_wings, m_wait;
    logic [1:0] m_owner;
    logic [5:0] m_id;
    bit         m_active, m_waiting, m_granted, m_release;
    logic [5:0] e_algo, e_wing;
    logic [3:0] e_grant, e_reject;
    logic       e_terr, e_busy;
    int         hold [NR];
    int         fw_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_wings = 0; m_wait = 0; m_owner = 2'd0; m_id = '0;
        m_active = 0; m_waiting = 0; m_granted = 0; m_release = 0;
        e_algo = '0; e_wing = '0; e_grant = '0; e_reject = '0; e_terr = 0; e_busy = 0;
    endtask

    task automatic model_step();
        int w;
        logic [1:0] j;
        logic [5:0] id;
        e_reject = '0;
        e_terr   = 1'b0;
        if (m_release) begin
            m_release = 0; m_active = 0; m_wings = 0;
            m_ptr = (int'(m_owner) + 1) % NR;
        end else if (!m_active) begin
            if (req != '0) begin
                w = -1;
                for (int k = 0; k < NR; k++) begin
                    j = 2'((m_ptr + k) % NR);
                    if (w < 0 && req[j]) w = int'(j);
                end
                id = 6'(req_algo >> (AW * w));
                if (int'(id) >= 50) begin
                    e_reject = 4'(1 << w);
                    m_ptr = (w + 1) % NR;
                end else begin
                    m_active = 1; m_owner = 2'(w); m_id = id; m_wings = 1;
                    m_waiting = 0; m_granted = 0;
                end
            end
        end else if (m_granted) begin
            if (done[m_owner] || !req[m_owner]) begin
                m_granted = 0; m_release = 1;
            end else if (!fw_ready) begin
                m_granted = 0; m_release = 1; e_terr = 1'b1;
            end
        end else if (m_waiting) begin
            if (fw_ready) begin
                m_waiting = 0; m_granted = 1;
            end else if (m_wait == 15) begin
                m_waiting = 0; m_release = 1; e_terr = 1'b1;
                e_reject = 4'(1 << m_owner);
            end else begin
                m_wait++;
            end
        end else if (m_wings < 6) begin
            m_wings++;
        end else begin
            m_waiting = 1; m_wait = 0;
        end
        e_busy  = m_active;
        e_algo  = m_active ? m_id : 6'd0;
        e_wing  = 6'((1 << m_wings) - 1);
        e_grant = m_granted ? 4'(1 << m_owner) : 4'd0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic set_id(input int i, input logic [5:0] id);
        req_algo[i*AW +: AW] = id;
    endtask

    task automatic clear_inputs();
        req = '0; done = '0; req_algo = '0; fw_ready = 1'b0;
        for (int i = 0; i < NR; i++) hold[i] = 0;
        fw_hold = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        cycle();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_algo"}, algo_select, 0);
        chk({name, "_wing"}, wing_en, 0);
        chk({name, "_grant"}, grant, 0);
        chk({name, "_reject"}, reject, 0);
        chk({name, "_terr"}, timeout_err, 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("m_algo_select", algo_select, e_algo);
            chk("m_wing_en", wing_en, e_wing);
            chk("m_grant", grant, e_grant);
            chk("m_reject", reject, e_reject);
            chk("m_timeout_err", timeout_err, e_terr);
            chk("m_busy", busy, e_busy);
            chk("grant_onehot", 32'($countones(grant) <= 1), 1);
            chk("grant_reject_excl", 32'((grant != '0) && (reject != '0)), 0);
        end
    end

    task automatic agent_step();
        logic [1:0] b;
        for (int i = 0; i < NR; i++) begin
            b = 2'(i);
            done[b] = 1'b0;
            if (req[b]) begin
                if (reject[b]) begin
                    req[b] = 1'b0;
                end else if (grant[b]) begin
                    if (hold[i] == 0) begin
                        done[b] = 1'b1;
                        hold[i] = $urandom_range(0, 4);
                        if ($urandom_range(0, 1) == 0) req[b] = 1'b0;
                    end else if ($urandom_range(0, 19) == 0) begin
                        req[b] = 1'b0;
                    end else begin
                        hold[i]--;
                    end
                end
            end else if ($urandom_range(0, 5) == 0) begin
                set_id(i, ($urandom_range(0, 9) == 0) ? 6'($urandom_range(50, 63))
                                                      : 6'($urandom_range(0, 49)));
                req[b]  = 1'b1;
                hold[i] = $urandom_range(0, 4);
            end
            if (!grant[b] && $urandom_range(0, 15) == 0) done[b] = 1'b1;
        end
        if (fw_hold == 0) begin
            fw_ready = ($urandom_range(0, 3) != 0);
            fw_hold  = fw_ready ? $urandom_range(1, 30) : $urandom_range(1, 24);
        end else begin
            fw_hold--;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_order [5];
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        chk_all_zero("reset");
        cmp_en = 1;
        do_reset();

        // Test 1: single request, ready tied high.
        fw_ready = 1'b1; set_id(0, 6'd7); req = 4'b0001;
        for (int n = 1; n <= 8; n++) begin
            cycle();
            chk("t1_algo_select", algo_select, 7);
            chk("t1_wing_en", wing_en, (n <= 6) ? ((1 << n) - 1) : 63);
            chk("t1_grant", grant, (n == 8) ? 1 : 0);
        end
        cycle(); cycle();
        done = 4'b0001;
        cycle();
        chk("t1_grant_clear", grant, 0);
        done = '0; req = '0;
        cycle();
        chk("t1_wing_off", wing_en, 0);
        chk("t1_idle", busy, 0);

        // Test 2: invalid id rejected for one cycle.
        set_id(1, 6'd50); req = 4'b0010;
        cycle();
        chk("t2_reject", reject, 4'b0010);
        chk("t2_busy", busy, 0);
        chk("t2_wing", wing_en, 0);
        req = '0;
        cycle();
        chk("t2_reject_pulse", reject, 0);
        chk("t2_busy2", busy, 0);

        // Test 3: all requesting, fair rotation.
        clear_inputs(); do_reset();
        fw_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_id(i, 6'(10 + i));
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int t = 0; t < 40 && grant == '0; t++) cycle();
            chk("t3_grant_order", grant, exp_order[g]);
            cycle(); cycle();
            done = grant;
            cycle();
            done = '0;
        end
        clear_inputs(); do_reset();

        // Test 4: ready never arrives.
        set_id(0, 6'd3); req = 4'b0001;
        for (int n = 1; n <= 24; n++) begin
            cycle();
            chk("t4_timeout_err", timeout_err, (n == 23) ? 1 : 0);
            chk("t4_reject", reject, (n == 23) ? 1 : 0);
            chk("t4_wing", wing_en, (n <= 6) ? ((1 << n) - 1) : ((n <= 23) ? 63 : 0));
            chk("t4_busy", busy, (n <= 23) ? 1 : 0);
            if (n == 23) req = '0;
        end

        // Test 5: ready loss while granted, then reset mid-warmup.
        clear_inputs(); do_reset();
        fw_ready = 1'b1; set_id(0, 6'd5); req = 4'b0001;
        repeat (9) cycle();
        chk("t5_granted", grant, 1);
        fw_ready = 1'b0;
        cycle();
        chk("t5_grant_drop", grant, 0);
        chk("t5_terr", timeout_err, 1);
        req = '0;
        cycle();
        chk("t5_terr_pulse", timeout_err, 0);
        fw_ready = 1'b1; set_id(0, 6'd9); req = 4'b0001;
        repeat (3) cycle();
        chk("t5_mid_warm", wing_en, 7);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_all_zero("t5_async_rst");
        clear_inputs();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        cycle();
        chk_all_zero("t5_rst_exit");

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            agent_step();
            cycle();
            if (c == 1500) begin
                clear_inputs();
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
